// File: rtl/smartcargo_pkg.sv
// smartcargo_pkg
//   Shared definitions for the smart_cargo front end: request frame width,
//   field slice positions inside the 7-bit request and the receiver FSM
//   state encoding.
package smartcargo_pkg;

    localparam int FRAME_DATA_BITS = 7;

    // Request layout: data[6:4] tipo, data[3:2] destino, data[1:0] origem
    localparam int TIPO_MSB    = 6;
    localparam int TIPO_LSB    = 4;
    localparam int DESTINO_MSB = 3;
    localparam int DESTINO_LSB = 2;
    localparam int ORIGEM_MSB  = 1;
    localparam int ORIGEM_LSB  = 0;

    localparam logic [2:0] EST_IDLE     = 3'd0;
    localparam logic [2:0] EST_START    = 3'd1;
    localparam logic [2:0] EST_DADOS    = 3'd2;
    localparam logic [2:0] EST_PARIDADE = 3'd3;
    localparam logic [2:0] EST_STOP     = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = EST_IDLE,
        ST_START    = EST_START,
        ST_DADOS    = EST_DADOS,
        ST_PARIDADE = EST_PARIDADE,
        ST_STOP     = EST_STOP
    } estado_t;

    // Odd parity: the parity bit makes the total count of ones odd
    function automatic logic paridade_impar(input logic [FRAME_DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/sincronizador_rx.sv
// sincronizador_rx
//   Flop chain bringing the asynchronous RX line into the clock domain.
//   Resets to 1 so an idle line does not look like a start bit.
// Ports
//   clock  in   system clock
//   reset  in   asynchronous active-low reset
//   din    in   raw serial line
//   dout   out  synchronised line (last stage)
module sincronizador_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] cadeia_q;
    logic [SYNC_STAGES-1:0] cadeia_d;

    always_comb begin
        cadeia_d = {cadeia_q[SYNC_STAGES-2:0], din};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cadeia_q <= '1;
        end else begin
            cadeia_q <= cadeia_d;
        end
    end

    assign dout = cadeia_q[SYNC_STAGES-1];

endmodule

// File: rtl/rx_pedido_serial.sv
// rx_pedido_serial
//   Serial request receiver. Frame: start(0), 7 data bits LSB first, odd
//   parity, stop(1). Good requests go into a 1-entry buffer drained with a
//   valid/ready handshake; parity, framing and overrun errors pulse 1 cycle.
// Ports
//   clock, reset        system clock, asynchronous active-low reset
//   RX                  serial line, idles high
//   pedido_pronto       consumer ready
//   pedido_valido       buffer holds an unconsumed request
//   tipo_objeto         request[6:4]
//   destino_objeto      request[3:2]
//   origem_objeto       request[1:0]
//   erro_paridade       parity mismatch pulse
//   erro_frame          stop bit sampled low pulse
//   erro_overrun        good frame dropped because buffer full pulse
//   ocupado             FSM not in IDLE
//
// state    | meaning
// IDLE     | line idle, waiting for rx_s low
// START    | waiting for start-bit mid-point, glitch rejection
// DADOS    | sampling the 7 data bits
// PARIDADE | sampling the parity bit
// STOP     | sampling the stop bit; verdict is applied on the next cycle
module rx_pedido_serial
    import smartcargo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       RX,
    input  logic       pedido_pronto,
    output logic       pedido_valido,
    output logic [2:0] tipo_objeto,
    output logic [1:0] destino_objeto,
    output logic [1:0] origem_objeto,
    output logic       erro_paridade,
    output logic       erro_frame,
    output logic       erro_overrun,
    output logic       ocupado
);

    localparam int BW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [BW-1:0] BAUD_FIM  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_MEIO = BW'((CLKS_PER_BIT - 1) / 2);
    // With one clock per bit the IDLE detection already is the start-bit
    // mid-point, so the START cycle lands on data bit 0 and samples it.
    localparam bit BIT_UNICO = (CLKS_PER_BIT == 1);

    logic rx_s;

    sincronizador_rx #(.SYNC_STAGES(SYNC_STAGES)) u_sinc (
        .clock (clock),
        .reset (reset),
        .din   (RX),
        .dout  (rx_s)
    );

    estado_t                      estado_q, estado_d;
    logic [BW-1:0]                baud_q, baud_d;
    logic [2:0]                   bit_q, bit_d;
    logic [FRAME_DATA_BITS-1:0]   sr_q, sr_d;
    logic                         par_q, par_d;
    logic                         stop_q, stop_d;
    logic                         avaliar_q, avaliar_d;
    logic                         valido_q, valido_d;
    logic [FRAME_DATA_BITS-1:0]   dados_q, dados_d;
    logic                         err_par_q, err_par_d;
    logic                         err_frm_q, err_frm_d;
    logic                         err_ovr_q, err_ovr_d;
    logic                         consumo;

    always_comb begin
        estado_d  = estado_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        sr_d      = sr_q;
        par_d     = par_q;
        stop_d    = stop_q;
        avaliar_d = 1'b0;
        valido_d  = valido_q;
        dados_d   = dados_q;
        err_par_d = 1'b0;
        err_frm_d = 1'b0;
        err_ovr_d = 1'b0;

        consumo = valido_q & pedido_pronto;
        if (consumo) begin
            valido_d = 1'b0;
        end

        // Verdict for the frame whose stop bit was sampled last cycle;
        // runs alongside IDLE so back-to-back frames are not delayed.
        if (avaliar_q) begin
            if (!stop_q) begin
                err_frm_d = 1'b1;
            end else if (par_q != paridade_impar(sr_q)) begin
                err_par_d = 1'b1;
            end else if (valido_q && !consumo) begin
                err_ovr_d = 1'b1;
            end else begin
                dados_d  = sr_q;
                valido_d = 1'b1;
            end
        end

        case (estado_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    estado_d = ST_START;
                    baud_d   = '0;
                    bit_d    = '0;
                end
            end
            ST_START: begin
                if (BIT_UNICO) begin
                    sr_d     = {rx_s, sr_q[FRAME_DATA_BITS-1:1]};
                    bit_d    = 3'd1;
                    baud_d   = '0;
                    estado_d = ST_DADOS;
                end else if (baud_q == BAUD_MEIO) begin
                    baud_d   = '0;
                    estado_d = rx_s ? ST_IDLE : ST_DADOS;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DADOS: begin
                if (baud_q == BAUD_FIM) begin
                    baud_d = '0;
                    sr_d   = {rx_s, sr_q[FRAME_DATA_BITS-1:1]};
                    if (bit_q == 3'd6) begin
                        estado_d = ST_PARIDADE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_PARIDADE: begin
                if (baud_q == BAUD_FIM) begin
                    baud_d   = '0;
                    par_d    = rx_s;
                    estado_d = ST_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_q == BAUD_FIM) begin
                    baud_d    = '0;
                    stop_d    = rx_s;
                    avaliar_d = 1'b1;
                    estado_d  = ST_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                estado_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= ST_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            sr_q      <= '0;
            par_q     <= 1'b0;
            stop_q    <= 1'b0;
            avaliar_q <= 1'b0;
            valido_q  <= 1'b0;
            dados_q   <= '0;
            err_par_q <= 1'b0;
            err_frm_q <= 1'b0;
            err_ovr_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            sr_q      <= sr_d;
            par_q     <= par_d;
            stop_q    <= stop_d;
            avaliar_q <= avaliar_d;
            valido_q  <= valido_d;
            dados_q   <= dados_d;
            err_par_q <= err_par_d;
            err_frm_q <= err_frm_d;
            err_ovr_q <= err_ovr_d;
        end
    end

    assign pedido_valido  = valido_q;
    assign tipo_objeto    = dados_q[TIPO_MSB:TIPO_LSB];
    assign destino_objeto = dados_q[DESTINO_MSB:DESTINO_LSB];
    assign origem_objeto  = dados_q[ORIGEM_MSB:ORIGEM_LSB];
    assign erro_paridade  = err_par_q;
    assign erro_frame     = err_frm_q;
    assign erro_overrun   = err_ovr_q;
    assign ocupado        = (estado_q != ST_IDLE);

endmodule
